// File: rtl/ofdm_demap_serializer.sv
// rtl/ofdm_demap_serializer.sv - OFDM hard-decision demapper and per-subcarrier serializer
// Optional 16-QAM decisions are enabled by defining DEMAP_QAM16_EN.
module ofdm_demap_serializer #(
    parameter  int N_SC = 8,
    parameter  int DW   = 24,
    localparam int IW   = $clog2(N_SC)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_SC*DW-1:0] in_real,
    input  logic [N_SC*DW-1:0] in_imag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_bits,
    output logic [IW-1:0]      out_idx,
    output logic               out_sof,
`ifdef DEMAP_QAM16_EN
    output logic               out_eof,
    input  logic               mode,
    input  logic [DW-2:0]      qam_thr
`else
    output logic               out_eof
`endif
);

    typedef enum logic {
        IDLE,
        SERIAL
    } state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_SC - 1);

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_inc;
    logic            last;
    logic            accept;
    logic            fire;

    logic [DW-1:0]   frame_re [N_SC];
    logic [DW-1:0]   frame_im [N_SC];

    logic [DW-1:0]   sel_re;
    logic [DW-1:0]   sel_im;
    logic            sign_re;
    logic            sign_im;
    logic [3:0]      dec;

    assign out_valid = (state == SERIAL);
    assign out_idx   = idx;
    assign last      = (idx == LAST_IDX);
    assign idx_inc   = idx + IW'(1);
    assign fire      = out_valid && out_ready;
    assign in_ready  = ((state == IDLE) || (fire && last)) && !flush;
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = SERIAL;
                SERIAL:  if (fire && last && !accept) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Frame storage carries no reset: a reset or flush drops the frame by leaving SERIAL.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < N_SC; k++) begin
                frame_re[k] <= in_real[k*DW +: DW];
                frame_im[k] <= in_imag[k*DW +: DW];
            end
        end
    end

    // The decision register is loaded in the same edge the frame arrives, so the
    // first decision must come straight from the input word rather than the frame register.
    always_comb begin
        sel_re = frame_re[idx_inc];
        sel_im = frame_im[idx_inc];
        if (accept) begin
            sel_re = in_real[DW-1:0];
            sel_im = in_imag[DW-1:0];
        end
    end

    assign sign_re = sel_re[DW-1];
    assign sign_im = sel_im[DW-1];

`ifdef DEMAP_QAM16_EN
    logic            mode_r;
    logic [DW-2:0]   thr_r;
    logic            sel_mode;
    logic [DW-2:0]   sel_thr;
    logic [DW-2:0]   mag_re;
    logic [DW-2:0]   mag_im;

    function automatic logic [DW-2:0] sat_abs(input logic [DW-1:0] x);
        logic [DW-2:0] result;
        if (!x[DW-1]) begin
            result = x[DW-2:0];
        end else if (x[DW-2:0] == '0) begin
            result = '1;
        end else begin
            result = ~x[DW-2:0] + (DW-1)'(1);
        end
        return result;
    endfunction

    always_ff @(posedge clk) begin
        if (accept) begin
            mode_r <= mode;
            thr_r  <= qam_thr;
        end
    end

    assign sel_mode = accept ? mode    : mode_r;
    assign sel_thr  = accept ? qam_thr : thr_r;
    assign mag_re   = sat_abs(sel_re);
    assign mag_im   = sat_abs(sel_im);

    always_comb begin
        dec = {2'b00, sign_im, sign_re ^ sign_im};
        if (sel_mode) begin
            dec = {sign_re, (mag_re < sel_thr), sign_im, (mag_im < sel_thr)};
        end
    end
`else
    logic unused_mag;

    assign unused_mag = ^{sel_re[DW-2:0], sel_im[DW-2:0]};

    always_comb begin
        dec = {2'b00, sign_im, sign_re ^ sign_im};
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx      <= '0;
            out_bits <= '0;
            out_sof  <= 1'b0;
            out_eof  <= 1'b0;
        end else if (flush) begin
            idx      <= '0;
            out_bits <= '0;
            out_sof  <= 1'b0;
            out_eof  <= 1'b0;
        end else if (accept) begin
            idx      <= '0;
            out_bits <= dec;
            out_sof  <= 1'b1;
            out_eof  <= 1'b0;
        end else if (fire) begin
            if (last) begin
                idx     <= '0;
                out_sof <= 1'b0;
                out_eof <= 1'b0;
            end else begin
                idx      <= idx_inc;
                out_bits <= dec;
                out_sof  <= 1'b0;
                out_eof  <= (idx_inc == LAST_IDX);
            end
        end
    end

endmodule

// File: tb/tb_ofdm_demap_serializer.sv
// tb/tb_ofdm_demap_serializer.sv - directed self-checking bench for ofdm_demap_serializer
module tb_ofdm_demap_serializer;

    localparam int N_SC = 8;
    localparam int DW   = 24;
    localparam int IW   = $clog2(N_SC);

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [N_SC*DW-1:0] in_real;
    logic [N_SC*DW-1:0] in_imag;
    logic               out_valid;
    logic               out_ready;
    logic [3:0]         out_bits;
    logic [IW-1:0]      out_idx;
    logic               out_sof;
    logic               out_eof;
`ifdef DEMAP_QAM16_EN
    logic               mode;
    logic [DW-2:0]      qam_thr;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ofdm_demap_serializer #(.N_SC(N_SC), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_idx   (out_idx),
        .out_sof   (out_sof),
`ifdef DEMAP_QAM16_EN
        .out_eof   (out_eof),
        .mode      (mode),
        .qam_thr   (qam_thr)
`else
        .out_eof   (out_eof)
`endif
    );

    task automatic set_sc(input int k, input int re, input int im);
        in_real[k*DW +: DW] = re[DW-1:0];
        in_imag[k*DW +: DW] = im[DW-1:0];
    endtask

    // Quadrant q of subcarrier k is (k+shift)%4, whose QPSK decision equals q.
    task automatic load_pattern(input int shift);
        for (int k = 0; k < N_SC; k++) begin
            case ((k + shift) % 4)
                0:       set_sc(k,  5,  5);
                1:       set_sc(k, -5,  5);
                2:       set_sc(k, -5, -5);
                default: set_sc(k,  5, -5);
            endcase
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_real = '0; in_imag = '0;
`ifdef DEMAP_QAM16_EN
        mode = 1'b0; qam_thr = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (out_bits !== 4'b0) $display("FAIL reset_bits: got %b expected 0000", out_bits); else n_pass++;
        n_checks++; if (out_idx !== '0) $display("FAIL reset_idx: got %0d expected 0", out_idx); else n_pass++;
        n_checks++; if ({out_sof, out_eof} !== 2'b00) $display("FAIL reset_sof_eof: got %b expected 00", {out_sof, out_eof}); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_single_frame;
        @(posedge clk); #1;
        load_pattern(0);
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL single_in_ready: got %b expected 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 0; k < N_SC; k++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) $display("FAIL single_valid k=%0d: got %b expected 1", k, out_valid); else n_pass++;
            n_checks++; if (out_idx !== IW'(k)) $display("FAIL single_idx k=%0d: got %0d expected %0d", k, out_idx, k); else n_pass++;
            n_checks++; if (out_bits !== 4'(k % 4)) $display("FAIL single_bits k=%0d: got %b expected %b", k, out_bits, 4'(k % 4)); else n_pass++;
            n_checks++; if (out_sof !== (k == 0)) $display("FAIL single_sof k=%0d: got %b expected %b", k, out_sof, k == 0); else n_pass++;
            n_checks++; if (out_eof !== (k == N_SC - 1)) $display("FAIL single_eof k=%0d: got %b expected %b", k, out_eof, k == N_SC - 1); else n_pass++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL single_idle: got %b expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_back_to_back;
        int  accepts;
        logic iv, ir;
        @(posedge clk); #1;
        load_pattern(0);
        in_valid = 1'b1; out_ready = 1'b1;
        accepts = 0;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            iv = in_valid; ir = in_ready;
            if (c >= 1 && c <= 16) begin
                n_checks++; if (out_valid !== 1'b1) $display("FAIL b2b_valid c=%0d: got %b expected 1", c, out_valid); else n_pass++;
                n_checks++; if (out_idx !== IW'((c - 1) % N_SC)) $display("FAIL b2b_idx c=%0d: got %0d expected %0d", c, out_idx, (c - 1) % N_SC); else n_pass++;
                n_checks++; if (out_bits !== 4'(((c - 1) % N_SC + (c > 8 ? 1 : 0)) % 4)) $display("FAIL b2b_bits c=%0d: got %b expected %b", c, out_bits, 4'(((c - 1) % N_SC + (c > 8 ? 1 : 0)) % 4)); else n_pass++;
            end
            if (c >= 1 && c <= 15) begin
                n_checks++; if (in_ready !== (c == 8)) $display("FAIL b2b_in_ready c=%0d: got %b expected %b", c, in_ready, c == 8); else n_pass++;
            end
            if (c == 17) begin
                n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_idle: got %b expected 0", out_valid); else n_pass++;
            end
            @(posedge clk); #1;
            if (iv && ir) begin
                accepts++;
                if (accepts == 1) load_pattern(1);
                if (accepts == 2) in_valid = 1'b0;
            end
        end
        n_checks++; if (accepts != 2) $display("FAIL b2b_accepts: got %0d expected 2", accepts); else n_pass++;
    endtask

    task automatic test_stall;
        int exp_idx;
        @(posedge clk); #1;
        load_pattern(3);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_idx = 0;
        for (int c = 0; c < 11; c++) begin
            out_ready = !(c >= 3 && c <= 5);
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b1) $display("FAIL stall_valid c=%0d: got %b expected 1", c, out_valid); else n_pass++;
            n_checks++; if (out_idx !== IW'(exp_idx)) $display("FAIL stall_idx c=%0d: got %0d expected %0d", c, out_idx, exp_idx); else n_pass++;
            n_checks++; if (out_bits !== 4'((exp_idx + 3) % 4)) $display("FAIL stall_bits c=%0d: got %b expected %b", c, out_bits, 4'((exp_idx + 3) % 4)); else n_pass++;
            if (out_ready) exp_idx++;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL stall_idle: got %b expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_flush;
        @(posedge clk); #1;
        load_pattern(0);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1;
        load_pattern(2);
        @(negedge clk);
        n_checks++; if (out_idx !== IW'(5)) $display("FAIL flush_at_idx: got %0d expected 5", out_idx); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", in_ready); else n_pass++;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (out_idx !== '0) $display("FAIL flush_idx: got %0d expected 0", out_idx); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_reaccept_ready: got %b expected 1", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if ({out_valid, out_sof} !== 2'b11) $display("FAIL flush_restart_vs: got %b expected 11", {out_valid, out_sof}); else n_pass++;
        n_checks++; if (out_idx !== '0) $display("FAIL flush_restart_idx: got %0d expected 0", out_idx); else n_pass++;
        n_checks++; if (out_bits !== 4'b0010) $display("FAIL flush_restart_bits: got %b expected 0010", out_bits); else n_pass++;
        repeat (8) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_drain: got %b expected 0", out_valid); else n_pass++;
    endtask

    task automatic test_extremes;
        @(posedge clk); #1;
        load_pattern(0);
        set_sc(0, 0, -1);
        set_sc(1, -(1 << (DW - 1)), 0);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_bits !== 4'b0011) $display("FAIL extreme_zero_neg1: got %b expected 0011", out_bits); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_bits !== 4'b0001) $display("FAIL extreme_min_zero: got %b expected 0001", out_bits); else n_pass++;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame;
        @(posedge clk); #1;
        load_pattern(0);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midreset_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if ({out_bits, out_idx} !== '0) $display("FAIL midreset_bits_idx: got %b/%0d expected 0/0", out_bits, out_idx); else n_pass++;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL midreset_after: got %b expected 01", {out_valid, in_ready}); else n_pass++;
    endtask

`ifdef DEMAP_QAM16_EN
    task automatic test_qam16;
        @(posedge clk); #1;
        load_pattern(0);
        set_sc(0, -500, 3000);
        set_sc(1, -(1 << (DW - 1)), 3000);
        set_sc(2, 0, -1);
        mode = 1'b1; qam_thr = (DW-1)'(1000);
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        mode = 1'b0; qam_thr = '0;
        @(negedge clk);
        n_checks++; if (out_bits !== 4'b1100) $display("FAIL qam_k0: got %b expected 1100", out_bits); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_bits !== 4'b1000) $display("FAIL qam_k1_sat: got %b expected 1000", out_bits); else n_pass++;
        @(negedge clk);
        n_checks++; if (out_bits !== 4'b0111) $display("FAIL qam_k2: got %b expected 0111", out_bits); else n_pass++;
        repeat (6) @(posedge clk);
        #1;
        load_pattern(0);
        set_sc(0, -500, 3000);
        mode = 1'b0; qam_thr = (DW-1)'(1000);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (out_bits !== 4'b0001) $display("FAIL qam_mode0: got %b expected 0001", out_bits); else n_pass++;
        repeat (8) @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_stall();
        test_flush();
        test_extremes();
        test_reset_mid_frame();
`ifdef DEMAP_QAM16_EN
        test_qam16();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
